// File: rtl/updown_seq_ctrl.sv
// Sequencer for the mod-MOD up/down counter.
// It owns the count register and the cu/cd direction selects. Commands
// (STOP/UP/DOWN/LOAD) arrive over a valid/ready handshake. A direction
// reversal passes through a one-cycle TURN state in which both selects are low.
module updown_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             tick,
  output logic             cu,
  output logic             cd,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             err,
  output logic [7:0]       wrap_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_TURN = 2'b11
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  // The modulus may equal 2^WIDTH, so the range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  // Wrap counter saturates instead of rolling over.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic load_oor(input logic [WIDTH-1:0] v);
    return ({1'b0, v} >= MOD_EXT);
  endfunction

  // Out-of-range load values are clamped to the top of the count range.
  function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
    return load_oor(v) ? MAX_CNT : v;
  endfunction

  state_t           state_q, state_d;
  logic             pend_down_q, pend_down_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             cu_q, cu_d;
  logic             cd_q, cd_d;
  logic             accept;

  assign cmd_ready = !rst && (state_q != ST_TURN);
  assign accept    = cmd_valid && cmd_ready;

  // Next-state, count step and pulse generation; an accepted command
  // takes priority over tick, which is then dropped.
  always_comb begin
    state_d     = state_q;
    pend_down_d = pend_down_q;
    count_d     = count_q;
    tc_d        = 1'b0;
    err_d       = 1'b0;
    wrap_d      = wrap_q;

    if (accept) begin
      case (cmd_op)
        OP_STOP: state_d = ST_IDLE;
        OP_UP: begin
          if (state_q == ST_DOWN) begin
            state_d     = ST_TURN;
            pend_down_d = 1'b0;
          end else begin
            state_d = ST_UP;
          end
        end
        OP_DOWN: begin
          if (state_q == ST_UP) begin
            state_d     = ST_TURN;
            pend_down_d = 1'b1;
          end else begin
            state_d = ST_DOWN;
          end
        end
        OP_LOAD: begin
          count_d = load_clamp(cmd_data);
          err_d   = load_oor(cmd_data);
          wrap_d  = 8'd0;
        end
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        ST_TURN: state_d = pend_down_q ? ST_DOWN : ST_UP;
        ST_UP: begin
          if (tick) begin
            if (count_q == MAX_CNT) begin
              count_d = '0;
              tc_d    = 1'b1;
              wrap_d  = sat_inc8(wrap_q);
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        ST_DOWN: begin
          if (tick) begin
            if (count_q == '0) begin
              count_d = MAX_CNT;
              tc_d    = 1'b1;
              wrap_d  = sat_inc8(wrap_q);
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
    end

    cu_d = (state_d == ST_UP);
    cd_d = (state_d == ST_DOWN);
  end

  // State, count and registered outputs; reset also discards a pending turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_down_q <= 1'b0;
      count_q     <= '0;
      tc_q        <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 8'd0;
      cu_q        <= 1'b0;
      cd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_down_q <= pend_down_d;
      count_q     <= count_d;
      tc_q        <= tc_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      cu_q        <= cu_d;
      cd_q        <= cd_d;
    end
  end

  assign state    = state_q;
  assign count    = count_q;
  assign tc       = tc_q;
  assign err      = err_q;
  assign wrap_cnt = wrap_q;
  assign cu       = cu_q;
  assign cd       = cd_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl (WIDTH=4, MOD=12).
module tb_updown_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       tick;
  logic       cu, cd, tc, err;
  logic [3:0] count;
  logic [7:0] wrap_cnt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  updown_seq_ctrl #(.WIDTH(4), .MOD(12)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick), .cu(cu), .cd(cd),
    .count(count), .tc(tc), .err(err), .wrap_cnt(wrap_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle command, tick unchanged.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0; tick = 1'b0;
    step(); step();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if ({cu, cd, tc, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b want=0000", {cu, cd, tc, err}); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap got=%0d want=0", wrap_cnt); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", cmd_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready); end
  endtask

  task automatic test_up_wrap();
    int tcs = 0;
    do_cmd(2'b01, 4'd0);
    checks++; if (state !== 2'b01 || cu !== 1'b1 || cd !== 1'b0) begin errors++; $display("FAIL up_enter got state=%0d cu=%b cd=%b want 1/1/0", state, cu, cd); end
    tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (count !== 4'(i % 12)) begin errors++; $display("FAIL up_count[%0d] got=%0d want=%0d", i, count, i % 12); end
      checks++; if (tc !== (i == 12)) begin errors++; $display("FAIL up_tc[%0d] got=%b want=%b", i, tc, (i == 12)); end
      if (tc) tcs++;
    end
    tick = 1'b0;
    checks++; if (tcs != 1) begin errors++; $display("FAIL up_tc_total got=%0d want=1", tcs); end
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL up_wrap got=%0d want=1", wrap_cnt); end
    checks++; if (cu !== 1'b1 || cd !== 1'b0) begin errors++; $display("FAIL up_dir got cu=%b cd=%b want 1/0", cu, cd); end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_c [4] = '{4'd2, 4'd1, 4'd0, 4'd11};
    do_cmd(2'b00, 4'd0);
    checks++; if (state !== 2'b00 || cu !== 1'b0) begin errors++; $display("FAIL stop got state=%0d cu=%b want 0/0", state, cu); end
    do_cmd(2'b11, 4'd3);
    checks++; if (count !== 4'd3 || err !== 1'b0 || wrap_cnt !== 8'd0) begin errors++; $display("FAIL load3 got count=%0d err=%b wrap=%0d want 3/0/0", count, err, wrap_cnt); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (count !== 4'd3 || state !== 2'b00) begin errors++; $display("FAIL idle_hold got count=%0d state=%0d want 3/0", count, state); end
    do_cmd(2'b10, 4'd0);
    checks++; if (state !== 2'b10 || cd !== 1'b1 || cu !== 1'b0 || count !== 4'd3) begin errors++; $display("FAIL down_enter got state=%0d cd=%b cu=%b count=%0d", state, cd, cu, count); end
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL down_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
      checks++; if (tc !== (i == 3)) begin errors++; $display("FAIL down_tc[%0d] got=%b want=%b", i, tc, (i == 3)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL down_err[%0d] got=%b want=0", i, err); end
    end
    tick = 1'b0;
  endtask

  task automatic test_turnaround();
    do_cmd(2'b11, 4'd5);
    // DOWN -> UP reversal; a STOP held during TURN must not be accepted.
    cmd_valid = 1'b1; cmd_op = 2'b01; step();
    cmd_op = 2'b00;
    checks++; if (state !== 2'b11 || cmd_ready !== 1'b0) begin errors++; $display("FAIL turn1 got state=%0d ready=%b want 3/0", state, cmd_ready); end
    step();
    cmd_valid = 1'b0;
    checks++; if (state !== 2'b01 || cu !== 1'b1 || count !== 4'd5) begin errors++; $display("FAIL turn1_exit got state=%0d cu=%b count=%0d want 1/1/5", state, cu, count); end
    // UP -> DOWN with tick held throughout.
    tick = 1'b1;
    do_cmd(2'b10, 4'd0);
    checks++; if (state !== 2'b11 || cmd_ready !== 1'b0 || cu !== 1'b0 || cd !== 1'b0 || count !== 4'd5) begin errors++; $display("FAIL turn2 got state=%0d ready=%b cu=%b cd=%b count=%0d", state, cmd_ready, cu, cd, count); end
    step();
    checks++; if (state !== 2'b10 || cd !== 1'b1 || count !== 4'd5) begin errors++; $display("FAIL turn2_exit got state=%0d cd=%b count=%0d want 2/1/5", state, cd, count); end
    step();
    checks++; if (count !== 4'd4 || tc !== 1'b0) begin errors++; $display("FAIL turn2_step got count=%0d tc=%b want 4/0", count, tc); end
    tick = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_cmd(2'b11, 4'd0);
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (count !== 4'd11 || tc !== 1'b1 || wrap_cnt !== 8'd1) begin errors++; $display("FAIL pre_clamp got count=%0d tc=%b wrap=%0d want 11/1/1", count, tc, wrap_cnt); end
    do_cmd(2'b11, 4'd14);
    checks++; if (count !== 4'd11 || err !== 1'b1 || wrap_cnt !== 8'd0) begin errors++; $display("FAIL load14 got count=%0d err=%b wrap=%0d want 11/1/0", count, err, wrap_cnt); end
    step();
    checks++; if (err !== 1'b0 || count !== 4'd11) begin errors++; $display("FAIL err_pulse got err=%b count=%0d want 0/11", err, count); end
    do_cmd(2'b11, 4'd12);
    checks++; if (count !== 4'd11 || err !== 1'b1) begin errors++; $display("FAIL load12 got count=%0d err=%b want 11/1", count, err); end
    do_cmd(2'b11, 4'd11);
    checks++; if (count !== 4'd11 || err !== 1'b0) begin errors++; $display("FAIL load11 got count=%0d err=%b want 11/0", count, err); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL load_keeps_state got=%0d want=2", state); end
  endtask

  task automatic test_cmd_priority();
    do_cmd(2'b11, 4'd7);
    do_cmd(2'b01, 4'd0);
    step();
    checks++; if (state !== 2'b01 || count !== 4'd7) begin errors++; $display("FAIL prio_setup got state=%0d count=%0d want 1/7", state, count); end
    tick = 1'b1;
    do_cmd(2'b01, 4'd0);
    checks++; if (count !== 4'd7 || tc !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL prio_drop got count=%0d tc=%b state=%0d want 7/0/1", count, tc, state); end
    step();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL prio_next got=%0d want=8", count); end
    tick = 1'b0;
  endtask

  task automatic test_wrap_saturation();
    int tcs = 0;
    do_cmd(2'b11, 4'd0);
    tick = 1'b1;
    for (int i = 0; i < 260 * 12; i++) begin
      step();
      if (tc) tcs++;
    end
    tick = 1'b0;
    checks++; if (tcs != 260) begin errors++; $display("FAIL sat_tc_total got=%0d want=260", tcs); end
    checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("FAIL sat_wrap got=%0d want=255", wrap_cnt); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL sat_count got=%0d want=0", count); end
  endtask

  task automatic test_reset_in_turn();
    tick = 1'b1;
    for (int i = 0; i < 9; i++) step();
    tick = 1'b0;
    do_cmd(2'b10, 4'd0);
    checks++; if (state !== 2'b11 || count !== 4'd9 || wrap_cnt !== 8'd255) begin errors++; $display("FAIL rturn_setup got state=%0d count=%0d wrap=%0d want 3/9/255", state, count, wrap_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'b00 || count !== 4'd0 || wrap_cnt !== 8'd0) begin errors++; $display("FAIL rturn got state=%0d count=%0d wrap=%0d want 0/0/0", state, count, wrap_cnt); end
    checks++; if (cu !== 1'b0 || cd !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rturn_flags got cu=%b cd=%b ready=%b want 0/0/1", cu, cd, cmd_ready); end
    step();
    checks++; if (state !== 2'b00 || cd !== 1'b0) begin errors++; $display("FAIL rturn_pending got state=%0d cd=%b want 0/0", state, cd); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_load_down();
    test_turnaround();
    test_load_clamp();
    test_cmd_priority();
    test_wrap_saturation();
    test_reset_in_turn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_seq_ctrl.md
# updown_seq_ctrl

Synchronous sequencer for the mod-N up/down counter datapath. It owns the count register and the direction lines (cu/cd) that select up or down counting. It accepts STOP/UP/DOWN/LOAD commands over a valid/ready handshake and inserts a one-cycle turnaround when the direction reverses. It also reports terminal-count wraps and out-of-range loads. It sits between the front-panel/command logic and the counter, replacing free-running CU/CD ties.

## Interface
- WIDTH, 4: count width in bits.
- MOD, 12: modulus; legal range 2..2^WIDTH; count range 0..MOD-1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  00 STOP, 01 UP, 10 DOWN, 11 LOAD.
- cmd_data  in  WIDTH  load value; used only for LOAD.
- tick  in  1  count enable; one step per cycle in which it is high.
- cu  out  1  count-up select; high iff state is UP.
- cd  out  1  count-down select; high iff state is DOWN.
- count  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle per wrap.
- err  out  1  one-cycle pulse: LOAD value ≥ MOD, clamped.
- wrap_cnt  out  8  wraps since reset/last LOAD; saturates at 255.
- state  out  2  00 IDLE, 01 UP, 10 DOWN, 11 TURN.

## Operation
- States:
  - IDLE: count holds; tick ignored.
  - UP: on tick, count = (count==MOD-1) ? 0 : count+1.
  - DOWN: on tick, count = (count==0) ? MOD-1 : count-1.
  - TURN: one cycle, cu=cd=0, tick ignored, then enters the pending direction.
- Transitions on an accepted command:
  - STOP: from any of IDLE/UP/DOWN → IDLE.
  - UP: IDLE→UP; UP→UP (no-op); DOWN→TURN→UP.
  - DOWN: IDLE→DOWN; DOWN→DOWN (no-op); UP→TURN→DOWN.
  - LOAD: count←cmd_data and wrap_cnt←0; state unchanged.
- LOAD with cmd_data ≥ MOD: count←MOD-1 and err pulses.
- cmd_ready = !rst && state != TURN.
- An accepted command in the same cycle as tick takes priority; that tick is dropped (no step, no tc).
- tc pulses on each wrap (MOD-1→0 up, 0→MOD-1 down); wrap_cnt increments with saturation at 255.
- Reset mid-operation, including in TURN: the pending direction is discarded and all state reinitialises.

## Timing
- Reset values: state=IDLE, count=0, cu=0, cd=0, tc=0, err=0, wrap_cnt=0, cmd_ready=0 while rst is high.
- All outputs except cmd_ready are registered. cmd_ready is combinational from state and rst.
- Count latency: tick high at edge N → count updated after edge N. tc is high during the cycle following edge N, aligned with the wrapped count value.
- Command latency: command accepted at edge N → new state, cu, cd and count visible after edge N.
- Reversal: turnaround takes two edges. Accept at edge N → TURN after edge N → new direction after edge N+1. First count step is possible at edge N+2.
- err is aligned with the clamped count value.
- With tick held high, counting sustains one step per cycle; no bubbles except at TURN and command cycles.

## Test plan
- Reset, then UP and tick held for 12 cycles with MOD=12 → count 1..11,0; tc high exactly once, with count=0; wrap_cnt=1; cu=1, cd=0.
- LOAD 3 from IDLE, then DOWN and 4 ticks → count 2,1,0,11; tc with count=11; err=0.
- In UP at count=5, issue DOWN with tick held → state TURN for one cycle, cmd_ready=0, cu=cd=0, count stays 5; then DOWN and count 4 on the next edge.
- LOAD 14 with MOD=12 → count=11, err pulses one cycle, wrap_cnt=0.
- Command accepted with tick high in UP at count=7 (same-direction UP) → count stays 7 that edge, steps to 8 on the next tick.
- Assert rst for one cycle while in TURN with count=9 → after that edge state=IDLE, count=0, cu=cd=0, wrap_cnt=0, cmd_ready=1.
